// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU with registered result/flags.
// Single-cycle ops finish on the accept edge. MUL/DIVU/REMU iterate one bit per cycle
// through a shared 2*WIDTH-bit accumulator.
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             overflow_flag,
    output logic             div_by_zero,
    output logic             illegal_op
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LastStep = SHW'(WIDTH - 1);

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpAnd  = 4'd2;
    localparam logic [3:0] OpOr   = 4'd3;
    localparam logic [3:0] OpXor  = 4'd4;
    localparam logic [3:0] OpSll  = 4'd5;
    localparam logic [3:0] OpSrl  = 4'd6;
    localparam logic [3:0] OpSra  = 4'd7;
    localparam logic [3:0] OpMul  = 4'd8;
    localparam logic [3:0] OpDivu = 4'd9;
    localparam logic [3:0] OpRemu = 4'd10;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Latched request and iteration state
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   m_q, m_d;        // multiplicand (MUL) or divisor (DIV/REM)
    logic [2*WIDTH-1:0] acc_q, acc_d;    // {high/remainder, low/quotient}
    logic [SHW-1:0]     cnt_q, cnt_d;

    // Registered outputs
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             dbz_q, dbz_d;
    logic             ill_q, ill_d;

    // Single-cycle evaluation of the incoming request
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic [SHW-1:0]   shamt;
    logic             b_is_zero;
    logic             sc_multi;
    logic [WIDTH-1:0] sc_result;
    logic             sc_carry;
    logic             sc_ovf;
    logic             sc_dbz;
    logic             sc_ill;

    // Iteration step results
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH-1:0]   div_shift;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step_acc;
    logic [WIDTH-1:0]   fin_result;
    logic               fin_ovf;

    // Combinational evaluation of single-cycle ops on the request inputs
    always_comb begin
        add_sum   = {1'b0, operand_a} + {1'b0, operand_b};
        sub_diff  = {1'b0, operand_a} - {1'b0, operand_b};
        shamt     = operand_b[SHW-1:0];
        b_is_zero = (operand_b == '0);
        sc_multi  = 1'b0;
        sc_result = '0;
        sc_carry  = 1'b0;
        sc_ovf    = 1'b0;
        sc_dbz    = 1'b0;
        sc_ill    = 1'b0;
        case (opcode)
            OpAdd: begin
                sc_result = add_sum[WIDTH-1:0];
                sc_carry  = add_sum[WIDTH];
                sc_ovf    = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                            (add_sum[WIDTH-1] != operand_a[WIDTH-1]);
            end
            OpSub: begin
                sc_result = sub_diff[WIDTH-1:0];
                sc_carry  = sub_diff[WIDTH];   // borrow, i.e. a < b unsigned
                sc_ovf    = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                            (sub_diff[WIDTH-1] != operand_a[WIDTH-1]);
            end
            OpAnd: sc_result = operand_a & operand_b;
            OpOr:  sc_result = operand_a | operand_b;
            OpXor: sc_result = operand_a ^ operand_b;
            OpSll: sc_result = operand_a << shamt;
            OpSrl: sc_result = operand_a >> shamt;
            OpSra: sc_result = WIDTH'($signed(operand_a) >>> shamt);
            OpMul: sc_multi = 1'b1;
            OpDivu: begin
                sc_multi  = !b_is_zero;
                sc_result = '1;
                sc_dbz    = b_is_zero;
            end
            OpRemu: begin
                sc_multi  = !b_is_zero;
                sc_result = operand_a;
                sc_dbz    = b_is_zero;
            end
            default: sc_ill = 1'b1;
        endcase
    end

    // One shift-add or restoring-subtract step on the accumulator
    always_comb begin
        // Add the multiplicand into the high half when the low bit is set, then shift right
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // The shifted remainder is WIDTH+1 bits wide; its top bit forces a subtract
        div_shift = {acc_q[2*WIDTH-2:WIDTH], acc_q[WIDTH-1]};
        div_ge    = acc_q[2*WIDTH-1] || (div_shift >= m_q);
        if (div_ge) begin
            div_next = {div_shift - m_q, acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {acc_q[2*WIDTH-2:0], 1'b0};
        end

        step_acc   = (op_q == OpMul) ? mul_next : div_next;
        fin_ovf    = 1'b0;
        fin_result = div_next[WIDTH-1:0];
        if (op_q == OpMul) begin
            fin_result = mul_next[WIDTH-1:0];
            fin_ovf    = (mul_next[2*WIDTH-1:WIDTH] != '0);
        end else if (op_q == OpRemu) begin
            fin_result = div_next[2*WIDTH-1:WIDTH];
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = sc_multi ? StBusy : StDone;
                end
            end
            StBusy: begin
                if (cnt_q == LastStep) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
    end

    // Datapath next-state: latch on accept, iterate in BUSY, load outputs on entry to DONE
    always_comb begin
        op_d     = op_q;
        m_d      = m_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        dbz_d    = dbz_q;
        ill_d    = ill_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d  = opcode;
                    cnt_d = '0;
                    if (sc_multi) begin
                        if (opcode == OpMul) begin
                            m_d   = operand_a;
                            acc_d = {{WIDTH{1'b0}}, operand_b};
                        end else begin
                            m_d   = operand_b;
                            acc_d = {{WIDTH{1'b0}}, operand_a};
                        end
                    end else begin
                        result_d = sc_result;
                        zero_d   = (sc_result == '0);
                        carry_d  = sc_carry;
                        ovf_d    = sc_ovf;
                        dbz_d    = sc_dbz;
                        ill_d    = sc_ill;
                    end
                end
            end
            StBusy: begin
                acc_d = step_acc;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == LastStep) begin
                    result_d = fin_result;
                    zero_d   = (fin_result == '0);
                    carry_d  = 1'b0;
                    ovf_d    = fin_ovf;
                    dbz_d    = 1'b0;
                    ill_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            op_q     <= op_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
            ill_q    <= ill_d;
        end
    end

    assign result        = result_q;
    assign zero_flag     = zero_q;
    assign carry_flag    = carry_q;
    assign overflow_flag = ovf_q;
    assign div_by_zero   = dbz_q;
    assign illegal_op    = ill_q;

endmodule
